// File: rtl/ahb_sram_slave_pkg.sv
// rtl/ahb_sram_slave_pkg.sv - shared AHB codes, slave state type and lane-merge helper
package ahb_sram_slave_pkg;

  localparam logic [1:0] TRANS_IDLE = 2'b00;
  localparam logic [1:0] TRANS_BUSY = 2'b01;
  localparam logic [1:0] TRANS_NSEQ = 2'b10;
  localparam logic [1:0] TRANS_SEQ  = 2'b11;

  localparam logic [1:0] SIZE_S08 = 2'b00;
  localparam logic [1:0] SIZE_S16 = 2'b01;
  localparam logic [1:0] SIZE_S32 = 2'b10;

  localparam logic RESP_OKAY  = 1'b0;
  localparam logic RESP_ERROR = 1'b1;

  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT
`ifdef AHB_SRAM_ERR_EN
    ,
    ST_ERR1,
    ST_ERR2
`endif
  } state_t;

  // Take new_word bytes on the enabled lanes, old_word bytes elsewhere.
  function automatic logic [31:0] merge_lanes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  lanes);
    logic [31:0] merged;
    merged = old_word;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) merged[8*b +: 8] = new_word[8*b +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/ahb_sram_slave_byte_lanes.sv
// rtl/ahb_sram_slave_byte_lanes.sv - little-endian byte-lane mask from transfer size and address
module ahb_byte_lanes
  import ahb_sram_slave_pkg::*;
(
  input  logic [1:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] lanes
);

  // Size 2'b11 falls into the word case; the error build rejects it before use.
  always_comb begin
    lanes = 4'b1111;
    case (size)
      SIZE_S08: lanes = 4'b0001 << addr_lo;
      SIZE_S16: lanes = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:  lanes = 4'b1111;
    endcase
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite word SRAM slave with wait states and RAW forwarding; AHB_SRAM_ERR_EN adds ERROR responses
module ahb_sram_slave
  import ahb_sram_slave_pkg::*;
#(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ahb_sel,
  input  logic [31:0] ahb_addr,
  input  logic [1:0]  ahb_trans,
  input  logic        ahb_write,
  input  logic [1:0]  ahb_size,
  input  logic [31:0] ahb_wdata,
  input  logic        ahb_ready_in,
  output logic [31:0] ahb_rdata,
  output logic        ahb_ready,
  output logic        ahb_resp
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_STATES[WAIT_CNT_W-1:0];

  logic [31:0] mem [DEPTH];

  state_t                  state;
  logic [WAIT_CNT_W-1:0]   wait_cnt;
  logic                    dp_write;
  logic [DEPTH_LOG2-1:0]   dp_idx;
  logic [3:0]              dp_lanes;
  logic                    ready_q;
  logic [31:0]             rdata_q;

  logic                    accept;
  logic                    wr_commit;
  logic [DEPTH_LOG2-1:0]   addr_idx;
  logic [3:0]              addr_lanes;
  logic [31:0]             rd_word;
  logic                    unused_bits;

  assign accept    = ahb_sel & ahb_trans[1] & ahb_ready_in;
  assign addr_idx  = ahb_addr[DEPTH_LOG2+1:2];
  assign wr_commit = dp_write & ready_q;

  ahb_byte_lanes u_lanes (
    .size    (ahb_size),
    .addr_lo (ahb_addr[1:0]),
    .lanes   (addr_lanes)
  );

  // A read accepted on the edge that retires a write to the same word sees the new bytes.
  assign rd_word = (wr_commit && (dp_idx == addr_idx))
                   ? merge_lanes(mem[addr_idx], ahb_wdata, dp_lanes)
                   : mem[addr_idx];

`ifdef AHB_SRAM_ERR_EN
  logic xfer_err;
  logic resp_q;

  assign xfer_err = (|(ahb_addr >> (DEPTH_LOG2 + 2)))
                  | (ahb_size == 2'b11)
                  | ((ahb_size == SIZE_S16) & ahb_addr[0])
                  | ((ahb_size == SIZE_S32) & (|ahb_addr[1:0]));
  assign ahb_resp    = resp_q;
  assign unused_bits = ahb_trans[0];
`else
  assign ahb_resp    = RESP_OKAY;
  assign unused_bits = ^{ahb_trans[0], ahb_addr[31:DEPTH_LOG2+2]};
`endif

  assign ahb_ready = ready_q;
  assign ahb_rdata = rdata_q;

  // No reset on the array: contents survive reset, only the pending write is dropped.
  always_ff @(posedge clk) begin
    if (!reset && wr_commit) begin
      for (int b = 0; b < 4; b++) begin
        if (dp_lanes[b]) mem[dp_idx][8*b +: 8] <= ahb_wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      wait_cnt <= '0;
      dp_write <= 1'b0;
      dp_idx   <= '0;
      dp_lanes <= '0;
      ready_q  <= 1'b1;
      rdata_q  <= '0;
`ifdef AHB_SRAM_ERR_EN
      resp_q   <= RESP_OKAY;
`endif
    end else begin
      case (state)
        ST_WAIT: begin
          if (wait_cnt == WAIT_CNT_W'(1)) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b1;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt - WAIT_CNT_W'(1);
          end
        end
`ifdef AHB_SRAM_ERR_EN
        ST_ERR1: begin
          state   <= ST_ERR2;
          ready_q <= 1'b1;
          resp_q  <= RESP_ERROR;
        end
`endif
        default: begin
          // Data phase ends here (ready high), so a new address phase may be taken.
          state    <= ST_IDLE;
          ready_q  <= 1'b1;
          dp_write <= 1'b0;
`ifdef AHB_SRAM_ERR_EN
          resp_q   <= RESP_OKAY;
`endif
          if (accept) begin
`ifdef AHB_SRAM_ERR_EN
            if (xfer_err) begin
              state   <= ST_ERR1;
              ready_q <= 1'b0;
              resp_q  <= RESP_ERROR;
            end else
`endif
            begin
              dp_write <= ahb_write;
              dp_idx   <= addr_idx;
              dp_lanes <= addr_lanes;
              if (!ahb_write) rdata_q <= rd_word;
              if (WAIT_INIT != '0) begin
                state    <= ST_WAIT;
                wait_cnt <= WAIT_INIT;
                ready_q  <= 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb/tb_ahb_sram_slave.sv - self-checking bench: zero-wait and 3-wait slaves against a sequential memory model
module tb_ahb_sram_slave;
  import ahb_sram_slave_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        sel   [2];
  logic [31:0] addr  [2];
  logic [1:0]  trans [2];
  logic        wr    [2];
  logic [1:0]  size  [2];
  logic [31:0] wdata [2];
  logic [31:0] rdata [2];
  logic        ready [2];
  logic        resp  [2];

  ahb_sram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst[0]), .ahb_sel(sel[0]), .ahb_addr(addr[0]), .ahb_trans(trans[0]),
    .ahb_write(wr[0]), .ahb_size(size[0]), .ahb_wdata(wdata[0]), .ahb_ready_in(ready[0]),
    .ahb_rdata(rdata[0]), .ahb_ready(ready[0]), .ahb_resp(resp[0])
  );

  ahb_sram_slave #(.DEPTH_LOG2(10), .WAIT_STATES(3)) dut3 (
    .clk(clk), .reset(rst[1]), .ahb_sel(sel[1]), .ahb_addr(addr[1]), .ahb_trans(trans[1]),
    .ahb_write(wr[1]), .ahb_size(size[1]), .ahb_wdata(wdata[1]), .ahb_ready_in(ready[1]),
    .ahb_rdata(rdata[1]), .ahb_ready(ready[1]), .ahb_resp(resp[1])
  );

  int checks = 0;
  int errors = 0;

  // Sequential memory model: every transfer takes effect in bus order.
  logic [31:0] mdl [2][1024];

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h", name, act, exp);
    end
  endtask

  function automatic int widx(input logic [31:0] a);
    return int'((a >> 2) & 32'h3FF);
  endfunction

  function automatic void mwrite(input int d, input logic [1:0] sz, input logic [31:0] a,
                                 input logic [31:0] wd);
    int idx, off, nb, first;
    idx   = widx(a);
    off   = int'(a % 4);
    nb    = (sz == SIZE_S08) ? 1 : (sz == SIZE_S16) ? 2 : 4;
    first = (sz == SIZE_S08) ? off : (sz == SIZE_S16) ? (off / 2) * 2 : 0;
    for (int k = first; k < first + nb; k++) mdl[d][idx][8*k +: 8] = wd[8*k +: 8];
  endfunction

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Drive one address phase, wait for the edge that takes it, then present data-phase wdata.
  task automatic issue(input int d, input logic s, input logic [1:0] tr, input logic w,
                       input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd,
                       output int waits);
    logic r;
    sel[d] = s; trans[d] = tr; wr[d] = w; size[d] = sz; addr[d] = a;
    waits = 0;
    forever begin
      r = ready[d];
      @(posedge clk);
      if (r) break;
      waits++;
      if (waits > 64) begin
        checks++;
        errors++;
        $display("FAIL accept_timeout dut=%0d waited=%0d limit=64", d, waits);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (s && tr[1] && w) wdata[d] = wd;
    sel[d] = 1'b0; trans[d] = TRANS_IDLE; wr[d] = 1'b0;
  endtask

  task automatic xfer(input int d, input logic w, input logic [1:0] sz, input logic [31:0] a,
                      input logic [31:0] wd);
    int waits;
    issue(d, 1'b1, TRANS_NSEQ, w, sz, a, wd, waits);
    if (d == 0) check("zero_wait_accept", waits, 0);
    check("resp_okay", resp[d], RESP_OKAY);
    if (w) mwrite(d, sz, a, wd);
    else   check("read_data", rdata[d], mdl[d][widx(a)]);
  endtask

  initial begin
    int waits, low;
    logic [1:0]  rsz;
    logic [31:0] ra;

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; sel[d] = 1'b0; addr[d] = '0; trans[d] = TRANS_IDLE;
      wr[d] = 1'b0; size[d] = SIZE_S32; wdata[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int d = 0; d < 2; d++) begin
      check("reset_ready", ready[d], 1);
      check("reset_resp",  resp[d],  0);
      check("reset_rdata", rdata[d], 0);
    end

    // Back-to-back zero-wait sequence including forwarding of full, byte and half writes.
    tbl[0] = '{1'b1, SIZE_S32, 32'h100, 32'h1122_3344, 32'h0};
    tbl[1] = '{1'b0, SIZE_S32, 32'h100, 32'h0,         32'h1122_3344};
    tbl[2] = '{1'b1, SIZE_S08, 32'h103, 32'hAA00_0000, 32'h0};
    tbl[3] = '{1'b0, SIZE_S32, 32'h100, 32'h0,         32'hAA22_3344};
    tbl[4] = '{1'b0, SIZE_S16, 32'h102, 32'h0,         32'hAA22_3344};
    tbl[5] = '{1'b1, SIZE_S16, 32'h100, 32'h0000_BEEF, 32'h0};
    tbl[6] = '{1'b0, SIZE_S08, 32'h101, 32'h0,         32'hAA22_BEEF};
    for (int i = 0; i < 7; i++) begin
      issue(0, 1'b1, TRANS_NSEQ, tbl[i].w, tbl[i].sz, tbl[i].a, tbl[i].wd, waits);
      check("tbl_zero_wait", waits, 0);
      if (tbl[i].w) mwrite(0, tbl[i].sz, tbl[i].a, tbl[i].wd);
      else          check("tbl_read", rdata[0], tbl[i].exp);
    end

    // IDLE, BUSY and deselected NSEQ write cycles leave memory alone.
    wdata[0] = 32'hFFFF_FFFF;
    issue(0, 1'b1, TRANS_IDLE, 1'b1, SIZE_S32, 32'h100, 32'h0, waits);
    check("idle_ready", ready[0], 1);
    check("idle_resp",  resp[0],  0);
    issue(0, 1'b1, TRANS_BUSY, 1'b1, SIZE_S32, 32'h100, 32'h0, waits);
    check("busy_ready", ready[0], 1);
    issue(0, 1'b0, TRANS_NSEQ, 1'b1, SIZE_S32, 32'h100, 32'h0, waits);
    check("unsel_ready", ready[0], 1);
    check("unsel_resp",  resp[0],  0);
    tick();
    xfer(0, 1'b0, SIZE_S32, 32'h100, 32'h0);
    check("idle_mem_kept", rdata[0], 32'hAA22_BEEF);

`ifdef AHB_SRAM_ERR_EN
    xfer(0, 1'b1, SIZE_S32, 32'h0, 32'h0102_0304);
    for (int k = 0; k < 2; k++) begin
      ra = (k == 0) ? 32'h0000_1002 : 32'h0010_0000;
      issue(0, 1'b1, TRANS_NSEQ, 1'b1, SIZE_S32, ra, 32'hFFFF_FFFF, waits);
      check("err1_ready", ready[0], 0);
      check("err1_resp",  resp[0],  1);
      tick();
      check("err2_ready", ready[0], 1);
      check("err2_resp",  resp[0],  1);
      tick();
      check("err_done_resp", resp[0], 0);
    end
    xfer(0, 1'b0, SIZE_S32, 32'h0, 32'h0);
    check("err_mem_kept", rdata[0], 32'h0102_0304);
`else
    xfer(0, 1'b1, SIZE_S32, 32'h0010_0000, 32'hCAFE_F00D);
    xfer(0, 1'b0, SIZE_S32, 32'h0, 32'h0);
    check("alias_word0", rdata[0], 32'hCAFE_F00D);
`endif

    // Three wait states: ready low exactly three cycles, rdata stable throughout.
    xfer(1, 1'b1, SIZE_S32, 32'h100, 32'h0BAD_CAFE);
    issue(1, 1'b1, TRANS_NSEQ, 1'b0, SIZE_S32, 32'h100, 32'h0, waits);
    check("w3_prev_waits", waits, 3);
    low = 0;
    while (ready[1] == 1'b0 && low < 10) begin
      low++;
      check("w3_rdata_stable", rdata[1], 32'h0BAD_CAFE);
      tick();
    end
    check("w3_low_cycles", low, 3);
    check("w3_rdata_end", rdata[1], 32'h0BAD_CAFE);
    mdl[1][widx(32'h100)] = 32'h0BAD_CAFE;

    // Reset inside a waited write data phase drops the write.
    xfer(1, 1'b1, SIZE_S32, 32'h200, 32'h5566_7788);
    issue(1, 1'b1, TRANS_NSEQ, 1'b1, SIZE_S32, 32'h200, 32'hDEAD_BEEF, waits);
    tick();
    check("rst_mid_ready_low", ready[1], 0);
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    check("rst_mid_ready", ready[1], 1);
    check("rst_mid_rdata", rdata[1], 0);
    xfer(1, 1'b0, SIZE_S32, 32'h200, 32'h0);
    check("rst_mid_old_word", rdata[1], 32'h5566_7788);

    // Randomised traffic on a 16-word window, both wait configurations.
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 16; i++) xfer(d, 1'b1, SIZE_S32, 32'h300 + 32'(4 * i), $urandom);
      for (int n = 0; n < ((d == 0) ? 300 : 150); n++) begin
        if ($urandom_range(0, 4) == 0) begin
          issue(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                SIZE_S32, 32'h300, $urandom, waits);
        end else begin
          rsz = 2'($urandom_range(0, 2));
          ra  = 32'h300 + 32'(4 * $urandom_range(0, 15));
          if (rsz == SIZE_S08) ra = ra + 32'($urandom_range(0, 3));
          if (rsz == SIZE_S16) ra = ra + 32'(2 * $urandom_range(0, 1));
          xfer(d, 1'($urandom_range(0, 1)), rsz, ra, $urandom);
        end
      end
    end

    repeat (6) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
